// File: rtl/clk_gen_divider.sv
// Programmable divided-clock source with a run/drain FSM and a period-aligned ratio reload.
// Optional feature: define CLKGEN_PERIOD_CNT_EN to add the period_cnt output.
module clk_gen_divider #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             div_ack,
    output logic             busy,
    output logic             clk_gen,
    output logic             clk_gen_rise
`ifdef CLKGEN_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    localparam int               DEF_INT = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [DIV_W-1:0] DEF_N   = DIV_W'(DEF_INT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Ratios below 2 cannot form a clock with both phases, so they clamp to 2.
    function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] v);
        return (v < DIV_W'(2)) ? DIV_W'(2) : v;
    endfunction

    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] n);
        logic [DIV_W:0] s;
        s = {1'b0, n} + (DIV_W+1)'(1);
        return s[DIV_W:1];
    endfunction

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] n, n_nxt;
    logic [DIV_W-1:0] pend, pend_nxt;
    logic             busy_nxt;
    logic             gen_nxt;
    logic             rise_nxt;
    logic             ack_nxt;
    logic             last;
    logic             apply;
    logic [DIV_W-1:0] cnt_adv;
`ifdef CLKGEN_PERIOD_CNT_EN
    logic [15:0]      pcnt, pcnt_nxt;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        n_nxt     = n;
        pend_nxt  = pend;
        busy_nxt  = busy;
        gen_nxt   = clk_gen;
        rise_nxt  = 1'b0;
        ack_nxt   = 1'b0;
        apply     = 1'b0;
        last      = (cnt == (n - DIV_W'(1)));
        cnt_adv   = last ? '0 : (cnt + DIV_W'(1));
`ifdef CLKGEN_PERIOD_CNT_EN
        pcnt_nxt  = pcnt;
`endif
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                gen_nxt = 1'b0;
                apply   = busy;
                if (en) begin
                    state_nxt = RUN;
                    gen_nxt   = 1'b1;
                    rise_nxt  = 1'b1;
                end
            end
            RUN, DRAIN: begin
                cnt_nxt  = cnt_adv;
                gen_nxt  = (cnt_adv < high_len(n));
                rise_nxt = last;
                apply    = busy && last;
`ifdef CLKGEN_PERIOD_CNT_EN
                if (last) pcnt_nxt = pcnt + 16'd1;
`endif
                // A stop request only takes hold once the running period has completed.
                if (en) begin
                    state_nxt = RUN;
                end else if (last) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    gen_nxt   = 1'b0;
                    rise_nxt  = 1'b0;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                gen_nxt   = 1'b0;
            end
        endcase

        // The previously pending ratio applies before a same-cycle load is captured.
        if (apply) begin
            n_nxt    = sat_div(pend);
            busy_nxt = 1'b0;
            ack_nxt  = 1'b1;
        end
        if (div_load) begin
            pend_nxt = div_value;
            busy_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            n            <= DEF_N;
            pend         <= '0;
            busy         <= 1'b0;
            clk_gen      <= 1'b0;
            clk_gen_rise <= 1'b0;
            div_ack      <= 1'b0;
`ifdef CLKGEN_PERIOD_CNT_EN
            pcnt         <= 16'd0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            n            <= n_nxt;
            pend         <= pend_nxt;
            busy         <= busy_nxt;
            clk_gen      <= gen_nxt;
            clk_gen_rise <= rise_nxt;
            div_ack      <= ack_nxt;
`ifdef CLKGEN_PERIOD_CNT_EN
            pcnt         <= pcnt_nxt;
`endif
        end
    end

`ifdef CLKGEN_PERIOD_CNT_EN
    assign period_cnt = pcnt;
`endif

endmodule

// File: tb/tb_clk_gen_divider.sv
// Scoreboard bench for clk_gen_divider: each driven cycle queues the outputs expected after
// the next clock edge; a negedge monitor pops and compares them.
module tb_clk_gen_divider;

    logic       clk;
    logic       rst;
    logic       en;
    logic       div_load;
    logic [7:0] div_value;
    logic       div_ack;
    logic       busy;
    logic       clk_gen;
    logic       clk_gen_rise;
`ifdef CLKGEN_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    typedef struct {
        string tag;
        logic  gen;
        logic  rise;
        logic  bsy;
        logic  ack;
        int    pc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    clk_gen_divider #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div_load     (div_load),
        .div_value    (div_value),
        .div_ack      (div_ack),
        .busy         (busy),
        .clk_gen      (clk_gen),
        .clk_gen_rise (clk_gen_rise)
`ifdef CLKGEN_PERIOD_CNT_EN
        ,
        .period_cnt   (period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, req);
        end
    endtask

    // One clock of stimulus plus the outputs required after the following rising edge.
    task automatic cyc(input logic r, input logic e, input logic l, input logic [7:0] v,
                       input logic g, input logic ri, input logic b, input logic a,
                       input int pc, input string tag);
        exp_t x;
        @(negedge clk);
        #1;
        rst       = r;
        en        = e;
        div_load  = l;
        div_value = v;
        x.tag = tag; x.gen = g; x.rise = ri; x.bsy = b; x.ack = a; x.pc = pc;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({x.tag, ".clk_gen"}, 32'(clk_gen), 32'(x.gen));
            check({x.tag, ".rise"},    32'(clk_gen_rise), 32'(x.rise));
            check({x.tag, ".busy"},    32'(busy), 32'(x.bsy));
            check({x.tag, ".ack"},     32'(div_ack), 32'(x.ack));
`ifdef CLKGEN_PERIOD_CNT_EN
            if (x.pc >= 0) check({x.tag, ".period_cnt"}, 32'(period_cnt), 32'(x.pc));
`endif
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; div_load = 1'b0; div_value = 8'd0;

        // Reset state
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 0, "rst0");
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 0, "rst1");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 0, "idle0");

        // Default ratio 2: alternate high/low, rise on every high cycle
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0, (i % 2) == 0, (i % 2) == 0, 0, 0, -1, "div2");
        end
        // cnt=1 shown; en drops on the last count: stop with no new period
        cyc(0, 0, 0, 0,   0, 0, 0, 0, -1, "div2_stop");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, -1, "div2_idle");

        // Load 4 in IDLE: busy, then ack on the next edge
        cyc(0, 0, 1, 4,   0, 0, 1, 0, -1, "ld4_busy");
        cyc(0, 0, 0, 0,   0, 0, 0, 1, -1, "ld4_ack");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, -1, "n4_c0");
        cyc(0, 1, 0, 0,   1, 0, 0, 0, -1, "n4_c1");
        // Load 5 while cnt=1: period finishes, ratio switches on the wrap
        cyc(0, 1, 1, 5,   0, 0, 1, 0, -1, "n4_c2");
        cyc(0, 1, 0, 0,   0, 0, 1, 0, -1, "n4_c3");
        cyc(0, 1, 0, 0,   1, 1, 0, 1, -1, "n5_c0");
        cyc(0, 1, 0, 0,   1, 0, 0, 0, -1, "n5_c1");
        cyc(0, 1, 0, 0,   1, 0, 0, 0, -1, "n5_c2");
        cyc(0, 1, 0, 0,   0, 0, 0, 0, -1, "n5_c3");
        cyc(0, 1, 0, 0,   0, 0, 0, 0, -1, "n5_c4");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, -1, "n5_c0b");

        // Load 0 -> behaves as 2
        cyc(0, 1, 1, 0,   1, 0, 1, 0, -1, "ld0_c1");
        cyc(0, 1, 0, 0,   1, 0, 1, 0, -1, "ld0_c2");
        cyc(0, 1, 0, 0,   0, 0, 1, 0, -1, "ld0_c3");
        cyc(0, 1, 0, 0,   0, 0, 1, 0, -1, "ld0_c4");
        cyc(0, 1, 0, 0,   1, 1, 0, 1, -1, "n0_c0");
        cyc(0, 1, 0, 0,   0, 0, 0, 0, -1, "n0_c1");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, -1, "n0_c0b");
        // Load 1 -> behaves as 2
        cyc(0, 1, 1, 1,   0, 0, 1, 0, -1, "ld1_c1");
        cyc(0, 1, 0, 0,   1, 1, 0, 1, -1, "n1_c0");
        cyc(0, 1, 0, 0,   0, 0, 0, 0, -1, "n1_c1");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, -1, "n1_c0b");

        // Load 7, then load 6 on the wrap edge: 7 applies, 6 stays pending
        cyc(0, 1, 1, 7,   0, 0, 1, 0, -1, "ld7");
        cyc(0, 1, 1, 6,   1, 1, 1, 1, -1, "wrap_ld6");
        for (int i = 1; i < 7; i++) begin
            cyc(0, 1, 0, 0, i < 4, 0, 1, 0, -1, "n7");
        end
        cyc(0, 1, 0, 0,   1, 1, 0, 1, -1, "n6_c0");
        cyc(0, 1, 0, 0,   1, 0, 0, 0, -1, "n6_c1");
        // en=0 at cnt=1: drain 2..5 then IDLE, no rise
        cyc(0, 0, 0, 0,   1, 0, 0, 0, -1, "drain_c2");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, -1, "drain_c3");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, -1, "drain_c4");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, -1, "drain_c5");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, -1, "drain_idle");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, -1, "drain_idle2");

        // N=5 running, load pending at cnt=2, then reset
        cyc(0, 0, 1, 5,   0, 0, 1, 0, -1, "ld5_busy");
        cyc(0, 0, 0, 0,   0, 0, 0, 1, -1, "ld5_ack");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, -1, "r5_c0");
        cyc(0, 1, 0, 0,   1, 0, 0, 0, -1, "r5_c1");
        cyc(0, 1, 1, 3,   1, 0, 1, 0, -1, "r5_c2");
        cyc(1, 1, 0, 0,   0, 0, 0, 0, 0,  "midrst");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, 0,  "postrst_c0");
        cyc(0, 1, 0, 0,   0, 0, 0, 0, -1, "postrst_c1");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, -1, "postrst_c0b");

        // N=3, three full periods, then stop on the last count
        cyc(1, 0, 0, 0,   0, 0, 0, 0, 0,  "rst_pc");
        cyc(0, 0, 1, 3,   0, 0, 1, 0, 0,  "ld3_busy");
        cyc(0, 0, 0, 0,   0, 0, 0, 1, 0,  "ld3_ack");
        cyc(0, 1, 0, 0,   1, 1, 0, 0, 0,  "n3_start");
        for (int p = 0; p < 3; p++) begin
            cyc(0, 1, 0, 0, 1, 0, 0, 0, p, "n3_c1");
            cyc(0, 1, 0, 0, 0, 0, 0, 0, p, "n3_c2");
            if (p < 2) cyc(0, 1, 0, 0, 1, 1, 0, 0, p + 1, "n3_wrap");
        end
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 3,  "n3_stop");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 3,  "n3_hold");
        cyc(0, 0, 0, 0,   0, 0, 0, 0, 3,  "n3_hold2");

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
